// File: rtl/gate_guard_pkg.sv
// gate_guard_pkg: shared types and constants for the gate_guard protection stage.
package gate_guard_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUN      = 2'd1,
        TRIP     = 2'd2
    } state_t;

    // Bit positions inside TripCause
    localparam int CAUSE_EXT   = 0;
    localparam int CAUSE_SHOOT = 1;

    localparam int TRIP_COUNT_WIDTH = 8;

    // Saturating increment used for the trip event counter
    function automatic logic [TRIP_COUNT_WIDTH-1:0] tripCountNext(
        input logic [TRIP_COUNT_WIDTH-1:0] count
    );
        if (count == {TRIP_COUNT_WIDTH{1'b1}}) begin
            return count;
        end
        return count + 1'b1;
    endfunction

endpackage

// File: rtl/gate_guard_sync.sv
// gate_guard_sync: two-flop synchronizer with a configurable reset value.
module gate_guard_sync #(
    parameter int               Width      = 1,
    parameter logic [Width-1:0] ResetValue = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    // Two-stage capture of the asynchronous input, forced to the reset value on reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= ResetValue;
            r_sync <= ResetValue;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_guard.sv
// gate_guard: protection stage between the PWM generator and the gate drivers.
// Registers the switch vector onto the driver pins, blocks truncated pulses on
// entry to run, trips on an external active-low fault and latches the trip
// until a timed clear.
// Optional feature: define GATE_GUARD_SHOOTTHRU_EN to trip on any pair whose
// high- and low-side switches are both requested on.
module gate_guard
    import gate_guard_pkg::*;
#(
    parameter int PairCount      = 24,
    parameter int FaultHoldWidth = 16
) (
    input  logic                          MClk,
    input  logic                          Rst,
    input  logic [2*PairCount-1:0]        SIn,
    input  logic                          Enable,
    input  logic                          FaultN,
    input  logic                          ClearFault,
    input  logic [FaultHoldWidth-1:0]     FaultHoldCount,
    output logic [2*PairCount-1:0]        SOut,
    output logic                          Running,
    output logic                          Fault,
    output logic [1:0]                    TripCause,
    output logic [$clog2(PairCount)-1:0]  TripPair,
    output logic [TRIP_COUNT_WIDTH-1:0]   TripCount
);

    localparam int PairIdxWidth = $clog2(PairCount);

    logic                        w_faultS;
    logic                        w_shootNow;
    logic                        w_tripNow;
    logic [PairIdxWidth-1:0]     w_tripPair;
    logic [2*PairCount-1:0]      w_rise;

    state_t                      r_state;
    logic [2*PairCount-1:0]      r_sInPrev;
    logic [2*PairCount-1:0]      r_released;
    logic [2*PairCount-1:0]      r_sOut;
    logic [1:0]                  r_tripCause;
    logic [PairIdxWidth-1:0]     r_tripPair;
    logic [TRIP_COUNT_WIDTH-1:0] r_tripCount;
    logic [FaultHoldWidth-1:0]   r_holdCnt;

    gate_guard_sync #(
        .Width      (1),
        .ResetValue (1'b1)
    ) u_faultSync (
        .i_clk (MClk),
        .i_rst (Rst),
        .i_d   (FaultN),
        .o_q   (w_faultS)
    );

`ifdef GATE_GUARD_SHOOTTHRU_EN
    logic [PairCount-1:0] w_overlap;

    // Flag every pair whose two switches are requested on together
    always_comb begin
        w_overlap = '0;
        for (int k = 0; k < PairCount; k++) begin
            w_overlap[k] = SIn[2*k] & SIn[2*k+1];
        end
    end

    // Lowest overlapping pair wins, scanning from the top down
    always_comb begin
        w_tripPair = '0;
        for (int k = PairCount - 1; k >= 0; k--) begin
            if (w_overlap[k]) begin
                w_tripPair = PairIdxWidth'(k);
            end
        end
    end

    assign w_shootNow = |w_overlap;
`else
    assign w_shootNow = 1'b0;
    assign w_tripPair = '0;
`endif

    assign w_rise    = SIn & ~r_sInPrev;
    assign w_tripNow = (r_state == RUN) && (!w_faultS || w_shootNow);

    // Protection state machine and all registered gate-side outputs
    always_ff @(posedge MClk) begin
        if (Rst) begin
            r_state     <= DISABLED;
            r_sInPrev   <= '0;
            r_released  <= '0;
            r_sOut      <= '0;
            r_tripCause <= '0;
            r_tripPair  <= '0;
            r_tripCount <= '0;
            r_holdCnt   <= '0;
        end else begin
            r_sInPrev <= SIn;
            case (r_state)
                DISABLED: begin
                    r_sOut <= '0;
                    if (Enable) begin
                        if (w_faultS) begin
                            r_state    <= RUN;
                            r_released <= '0;
                        end else begin
                            r_state                <= TRIP;
                            r_tripCause            <= '0;
                            r_tripCause[CAUSE_EXT] <= 1'b1;
                            r_tripPair             <= '0;
                            r_tripCount            <= tripCountNext(r_tripCount);
                            r_holdCnt              <= '0;
                        end
                    end
                end
                RUN: begin
                    if (w_tripNow) begin
                        r_state                  <= TRIP;
                        r_sOut                   <= '0;
                        r_tripCause[CAUSE_EXT]   <= !w_faultS;
                        r_tripCause[CAUSE_SHOOT] <= w_shootNow;
                        r_tripPair               <= w_tripPair;
                        r_tripCount              <= tripCountNext(r_tripCount);
                        r_holdCnt                <= '0;
                    end else if (!Enable) begin
                        r_state <= DISABLED;
                        r_sOut  <= '0;
                    end else begin
                        r_released <= r_released | w_rise;
                        r_sOut     <= SIn & (r_released | w_rise);
                    end
                end
                TRIP: begin
                    r_sOut <= '0;
                    if (r_holdCnt < FaultHoldCount) begin
                        r_holdCnt <= r_holdCnt + 1'b1;
                    end else begin
                        r_holdCnt <= FaultHoldCount;
                    end
                    if (ClearFault && (r_holdCnt == FaultHoldCount) && w_faultS) begin
                        if (Enable) begin
                            r_state    <= RUN;
                            r_released <= '0;
                        end else begin
                            r_state <= DISABLED;
                        end
                    end
                end
                default: begin
                    r_state <= DISABLED;
                    r_sOut  <= '0;
                end
            endcase
        end
    end

    assign SOut      = r_sOut;
    assign Running   = (r_state == RUN);
    assign Fault     = (r_state == TRIP);
    assign TripCause = r_tripCause;
    assign TripPair  = r_tripPair;
    assign TripCount = r_tripCount;

endmodule

// File: tb/tb_gate_guard.sv
// tb_gate_guard: directed scoreboard bench for gate_guard.
// Each stimulus cycle pushes the hand-computed state expected after the next
// clock edge; an independent monitor pops and compares one entry per cycle.
module tb_gate_guard;

    localparam int PairCount = 24;
    localparam int SW        = 2 * PairCount;

    logic          MClk = 1'b0;
    logic          Rst;
    logic [SW-1:0] SIn;
    logic          Enable;
    logic          FaultN;
    logic          ClearFault;
    logic [15:0]   FaultHoldCount;
    logic [SW-1:0] SOut;
    logic          Running;
    logic          Fault;
    logic [1:0]    TripCause;
    logic [4:0]    TripPair;
    logic [7:0]    TripCount;

    typedef struct {
        logic [SW-1:0] sout;
        logic          running;
        logic          fault;
        logic [1:0]    cause;
        logic [4:0]    pair;
        logic [7:0]    count;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;

    gate_guard #(
        .PairCount      (PairCount),
        .FaultHoldWidth (16)
    ) dut (
        .MClk           (MClk),
        .Rst            (Rst),
        .SIn            (SIn),
        .Enable         (Enable),
        .FaultN         (FaultN),
        .ClearFault     (ClearFault),
        .FaultHoldCount (FaultHoldCount),
        .SOut           (SOut),
        .Running        (Running),
        .Fault          (Fault),
        .TripCause      (TripCause),
        .TripPair       (TripPair),
        .TripCount      (TripCount)
    );

    // Free-running system clock
    always #5 MClk = ~MClk;

    function automatic exp_t mkExp(input logic [SW-1:0] s, input int r, input int f,
                                   input int c, input int p, input int n);
        exp_t e;
        e.sout    = s;
        e.running = (r != 0);
        e.fault   = (f != 0);
        e.cause   = c[1:0];
        e.pair    = p[4:0];
        e.count   = n[7:0];
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Drive one cycle of inputs shortly after the edge and queue what the next edge must produce
    task automatic applyStimulus(input int rst, input int en, input int fn, input int clr,
                                 input logic [SW-1:0] sin, input exp_t e, input string name);
        @(posedge MClk);
        #2;
        Rst        = (rst != 0);
        Enable     = (en != 0);
        FaultN     = (fn != 0);
        ClearFault = (clr != 0);
        SIn        = sin;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    // Monitor: one step after each edge, compare the outputs with the oldest queued expectation
    always @(posedge MClk) begin : monitor
        exp_t  e;
        string n;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput({n, ".SOut"},      64'(SOut),      64'(e.sout));
            checkOutput({n, ".Running"},   64'(Running),   64'(e.running));
            checkOutput({n, ".Fault"},     64'(Fault),     64'(e.fault));
            checkOutput({n, ".TripCause"}, 64'(TripCause), 64'(e.cause));
            checkOutput({n, ".TripPair"},  64'(TripPair),  64'(e.pair));
            checkOutput({n, ".TripCount"}, 64'(TripCount), 64'(e.count));
        end
    end

    // Directed stimulus sequence
    initial begin : stimulus
        int c;
        Rst            = 1'b1;
        Enable         = 1'b0;
        FaultN         = 1'b1;
        ClearFault     = 1'b0;
        SIn            = '0;
        FaultHoldCount = 16'd10;

        // Reset, then enter run and follow pair 0 with gaps
        applyStimulus(1, 0, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "reset_a");
        applyStimulus(1, 0, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "reset_b");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "enter_run");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "p0_hi");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "p0_gap1");
        applyStimulus(0, 1, 1, 0, 48'h2, mkExp(48'h2, 1, 0, 0, 0, 0), "p0_lo");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "p0_gap2");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "p0_hi2");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "p0_hold");

        // Enable rising while the channel is already high must not release it
        applyStimulus(0, 0, 1, 0, 48'h1, mkExp(48'h0, 0, 0, 0, 0, 0), "disable");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h0, 1, 0, 0, 0, 0), "enable_while_high");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h0, 1, 0, 0, 0, 0), "no_release_mid_pulse");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "fall");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "release_on_edge");

`ifdef GATE_GUARD_SHOOTTHRU_EN
        // Pair 5 overlap trips in the same cycle it appears
        applyStimulus(0, 1, 1, 0, 48'hC01, mkExp(48'h0, 0, 1, 2, 5, 1), "shoot_trip");
        FaultHoldCount = 16'd0;
        applyStimulus(0, 1, 1, 1, 48'h0, mkExp(48'h0, 1, 0, 2, 5, 1), "clear_first_cycle");
        applyStimulus(0, 1, 1, 0, 48'hC0C0, mkExp(48'h0, 0, 1, 2, 3, 2), "lowest_pair");
`else
        // Without overlap detection the pattern passes straight through
        applyStimulus(0, 1, 1, 0, 48'hC01, mkExp(48'hC01, 1, 0, 0, 0, 0), "no_shoot_check");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "no_shoot_idle");
`endif
        applyStimulus(1, 0, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "reset_c");

        // External fault: trip on the third edge, timed clear with hold of 10
        FaultHoldCount = 16'd10;
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "d_run");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "d_out");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "fault_edge1");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h1, 1, 0, 0, 0, 0), "fault_edge2");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 1), "fault_trip");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 1), "trip_c1");
        for (int k = 2; k <= 11; k++) begin
            if (k == 5) begin
                applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 1), "clear_cycle5_ignored");
            end else if (k == 10) begin
                applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 1), "clear_cycle10_ignored");
            end else begin
                applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 1), "trip_hold");
            end
        end
        applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 1, 0, 1, 0, 1), "clear_cycle12_accepted");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h0, 1, 0, 1, 0, 1), "no_release_after_clear");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 1, 0, 1), "post_clear_fall");
        applyStimulus(0, 1, 1, 0, 48'h1, mkExp(48'h1, 1, 0, 1, 0, 1), "post_clear_edge");

        // Clear requests while the synchronized fault is still low are ignored
        FaultHoldCount = 16'd0;
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h1, 1, 0, 1, 0, 1), "e_edge1");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h1, 1, 0, 1, 0, 1), "e_edge2");
        applyStimulus(0, 1, 0, 0, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 2), "e_trip");
        applyStimulus(0, 1, 0, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 2), "clear_fault_low1");
        applyStimulus(0, 1, 0, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 2), "clear_fault_low2");
        applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 2), "clear_sync_stage1");
        applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 0, 1, 1, 0, 2), "clear_sync_stage2");
        applyStimulus(0, 1, 1, 1, 48'h1, mkExp(48'h0, 1, 0, 1, 0, 2), "clear_after_fault_high");

        // Trip counter saturation over 300 trips
        applyStimulus(1, 0, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "reset_f");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 1, 0, 0, 0, 0), "f_run");
        for (int i = 1; i <= 300; i++) begin
            c = (i > 255) ? 255 : i;
            applyStimulus(0, 1, 0, 0, 48'h0, mkExp(48'h0, 1, 0, (i == 1) ? 0 : 1, 0, c - 1 + ((i > 255) ? 1 : 0)), "sat_edge1");
            applyStimulus(0, 1, 0, 0, 48'h0, mkExp(48'h0, 1, 0, (i == 1) ? 0 : 1, 0, c - 1 + ((i > 255) ? 1 : 0)), "sat_edge2");
            applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, c), "sat_trip");
            applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, c), "sat_hold");
            applyStimulus(0, 1, 1, 1, 48'h0, mkExp(48'h0, 1, 0, 1, 0, c), "sat_clear");
        end

        // One more trip stays saturated, then reset in the middle of TRIP
        applyStimulus(0, 1, 0, 0, 48'h0, mkExp(48'h0, 1, 0, 1, 0, 255), "g_edge1");
        applyStimulus(0, 1, 0, 0, 48'h0, mkExp(48'h0, 1, 0, 1, 0, 255), "g_edge2");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, 255), "trip_saturated");
        applyStimulus(1, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "reset_mid_trip");

        // Enable with the fault already active trips straight from DISABLED
        applyStimulus(0, 0, 0, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "h_idle1");
        applyStimulus(0, 0, 0, 0, 48'h0, mkExp(48'h0, 0, 0, 0, 0, 0), "h_idle2");
        applyStimulus(0, 1, 0, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, 1), "disabled_fault_trip");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, 1), "h_sync1");
        applyStimulus(0, 1, 1, 0, 48'h0, mkExp(48'h0, 0, 1, 1, 0, 1), "h_sync2");
        applyStimulus(0, 0, 1, 1, 48'h0, mkExp(48'h0, 0, 0, 1, 0, 1), "clear_to_disabled");
        applyStimulus(0, 0, 1, 0, 48'h0, mkExp(48'h0, 0, 0, 1, 0, 1), "h_stay_disabled");

        // Let the monitor drain the queue within a bounded number of cycles
        for (int w = 0; w < 4 && expQ.size() > 0; w++) begin
            @(posedge MClk);
            #2;
        end
        if (expQ.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gate_guard.md
# gate_guard

Protection stage directly downstream of the PWM generator top. Consumes the full complementary switch vector and registers it onto the gate-driver pins. Blocks shoot-through (both switches of a pair on), trips on an external active-low fault and latches the trip until a timed clear. On entry to run, releases each channel only on its first clean rising edge, so no truncated pulse reaches a driver.

## Interface
- PairCount, default 24: number of switch pairs; equals PhaseCount*InterleaveCount*LevelCount (3*4*2).
- FaultHoldWidth, default 16: width of the trip hold counter.
- MClk  in  1  system clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- SIn  in  2*PairCount  switch vector from the generator; pair k = {SIn[2k+1] low-side, SIn[2k] high-side}.
- Enable  in  1  level; 1 requests run.
- FaultN  in  1  asynchronous external fault, active-low.
- ClearFault  in  1  single-cycle clear request.
- FaultHoldCount  in  FaultHoldWidth  minimum cycles spent in TRIP before a clear is accepted.
- SOut  out  2*PairCount  registered gate outputs.
- Running  out  1  state == RUN.
- Fault  out  1  state == TRIP.
- TripCause  out  2  bit0 external fault, bit1 shoot-through; captured on trip entry.
- TripPair  out  $clog2(PairCount)  lowest pair index in overlap at trip; 0 if none.
- TripCount  out  8  saturating count of TRIP entries.

## Operation
- FaultN passes through a 2-flop synchronizer; both flops reset to 1. FaultS is the synchronized value.
- States: DISABLED, RUN, TRIP. Reset goes to DISABLED.
- ShootNow = any pair with both bits of SIn high (combinational).
- TripNow = (state==RUN) & (!FaultS | ShootNow).
- DISABLED:
  - SOut = 0.
  - Enable=1 & FaultS=1 -> RUN. On this transition, all Released bits clear.
  - Enable=1 with FaultS=0 -> TRIP, cause bit0.
- RUN:
  - Per channel j, Released[j] sets when SIn[j] was 0 on the previous cycle and is 1 now.
  - SOut[j] <= SIn[j] & (Released[j] | rising edge now) & !TripNow.
  - TripNow -> TRIP. In that case SOut <= 0, TripCause and TripPair are captured, and TripCount increments, saturating at 255.
  - Enable=0 -> DISABLED, SOut <= 0. TripNow takes priority over Enable=0.
- TRIP:
  - SOut = 0; the hold counter counts up from 0 and saturates at FaultHoldCount.
  - ClearFault is accepted only when counter == FaultHoldCount and FaultS=1. It is ignored otherwise; no queuing.
  - An accepted clear goes to RUN (Released cleared) if Enable=1, else to DISABLED. TripCause and TripPair persist until the next trip or reset.
  - FaultHoldCount=0 allows a clear on the first TRIP cycle.
- Rst in any state: DISABLED, SOut=0, counters 0, cause 0, sync flops 1.

## Timing
- SIn to SOut latency: 1 cycle in RUN.
- An overlapping SIn pattern never appears on SOut; it is gated in the same cycle it appears.
- FaultN falling (setup met) -> SOut all 0 after the 3rd rising edge; Fault=1 on the same edge.
- An accepted ClearFault -> Fault=0 on the next edge.
- Pair outputs re-emerge no earlier than each channel's next rising edge.
- Reset values: SOut 0, Running 0, Fault 0, TripCause 0, TripPair 0, TripCount 0.

## Configuration
- GATE_GUARD_SHOOTTHRU_EN defined: overlap detection is active as described.
- Not defined:
  - ShootNow is tied to 0.
  - TripCause[1] and TripPair are constant 0.
  - Only FaultS trips the block.

## Structure
- Package gate_guard_pkg holds:
  - the state enum (DISABLED, RUN, TRIP);
  - the TripCause bit positions (CAUSE_EXT=0, CAUSE_SHOOT=1);
  - the TripCount width constant.
- One sub-module, gate_guard_sync: a parameterized 2-flop synchronizer with a reset value parameter. It is instantiated for FaultN.

## Test plan
- Reset, Enable=1, SIn pair 0 toggling complementary with gaps -> SOut pair 0 follows SIn with 1-cycle delay, starting at its first rising edge after RUN.
- Enable rises while SIn[0]=1 -> SOut[0] stays 0 until SIn[0] falls and rises again.
- In RUN, force SIn pair 5 = 2'b11 for 1 cycle -> SOut never shows 11; Fault=1; TripCause=2'b10; TripPair=5; TripCount=1.
- FaultN low for 4 cycles -> SOut=0 by the 3rd edge; TripCause=2'b01. With FaultHoldCount=10, ClearFault at TRIP cycle 5 is ignored and at cycle 12 is accepted -> RUN.
- ClearFault with FaultN still low -> stays TRIP. 300 trips -> TripCount=255. Rst mid-TRIP -> all outputs 0, DISABLED.
